// File: rtl/fp16_adder_arbiter_pkg.sv
// Shared definitions for the FP16 adder arbiter.
//   - FP16 field positions (1 sign / 5 exponent / 10 mantissa bits)
//   - FSM state encoding used by the top level
package fp16_adder_arbiter_pkg;

   localparam int FP16_W   = 16;
   localparam int SIGN_BIT = 15;
   localparam int EXP_MSB  = 14;
   localparam int EXP_LSB  = 10;
   localparam int MAN_MSB  = 9;
   localparam int MAN_LSB  = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/fp16_adder_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req_i   - request vector, one bit per requester
//   ptr_i   - index of the highest-priority requester
//   grant_o - one-hot grant (zero when no request is set)
module fp16_adder_arbiter_rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int PTR_W   = 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PTR_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] grant_o
);

   localparam logic [NUM_REQ-1:0] ALL_ONES = '1;
   localparam logic [NUM_REQ-1:0] ONE      = {{(NUM_REQ-1){1'b0}}, 1'b1};

   logic [NUM_REQ-1:0] masked;

   // Requests at or above ptr_i win first; if none, wrap to the lowest index.
   // x & (~x + 1) isolates the lowest set bit.
   always_comb begin
      masked = req_i & (ALL_ONES << ptr_i);
      if (|masked) begin
         grant_o = masked & (~masked + ONE);
      end else begin
         grant_o = req_i & (~req_i + ONE);
      end
   end

endmodule

// File: rtl/fp16_adder_arbiter.sv
// Shares one external combinational FP16 add/sub datapath among NUM_REQ
// requesters. Round-robin arbitration, one operation in flight at a time.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   req_valid_i / req_ready_o  - per-requester operation handshake
//   req_a_i, req_b_i           - packed FP16 operands, slice i = [16*i+15:16*i]
//   req_sub_i                  - per-requester op select (1 = A-B)
//   resp_valid_o / resp_ready_i- per-requester result handshake
//   resp_data_o                - FP16 result, held while resp_valid_o is set
//   add_a_o, add_b_o, add_sub_o- operand registers to the datapath
//   add_c_i                    - datapath result
//   busy_o                     - operation in flight
module fp16_adder_arbiter
   import fp16_adder_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = 2,
   parameter int ADDER_LAT = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   input  logic [FP16_W*NUM_REQ-1:0] req_a_i,
   input  logic [FP16_W*NUM_REQ-1:0] req_b_i,
   input  logic [NUM_REQ-1:0]        req_sub_i,
   output logic [NUM_REQ-1:0]        resp_valid_o,
   input  logic [NUM_REQ-1:0]        resp_ready_i,
   output logic [FP16_W-1:0]         resp_data_o,
   output logic [FP16_W-1:0]         add_a_o,
   output logic [FP16_W-1:0]         add_b_o,
   output logic                      add_sub_o,
   input  logic [FP16_W-1:0]         add_c_i,
   output logic                      busy_o
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(ADDER_LAT + 1);
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(ADDER_LAT - 1);
   localparam logic [PTR_W-1:0]   LAST_REQ = PTR_W'(NUM_REQ - 1);

   state_e               state_q;
   logic [PTR_W-1:0]     rr_ptr_q;
   logic [PTR_W-1:0]     owner_q;
   logic [CNT_W-1:0]     lat_cnt_q;
   logic [FP16_W-1:0]    a_q;
   logic [FP16_W-1:0]    b_q;
   logic                 sub_q;
   logic [FP16_W-1:0]    result_q;
   logic [NUM_REQ-1:0]   resp_valid_q;
   logic                 busy_q;

   logic [NUM_REQ-1:0]   grant;
   logic [PTR_W-1:0]     grant_idx;
   logic [FP16_W-1:0]    req_a_arr [NUM_REQ];
   logic [FP16_W-1:0]    req_b_arr [NUM_REQ];

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
         assign req_a_arr[gi] = req_a_i[FP16_W*gi +: FP16_W];
         assign req_b_arr[gi] = req_b_i[FP16_W*gi +: FP16_W];
      end
   endgenerate

   fp16_adder_arbiter_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_arbiter (
      .req_i   (req_valid_i),
      .ptr_i   (rr_ptr_q),
      .grant_o (grant)
   );

   always_comb begin
      grant_idx = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (grant[j]) begin
            grant_idx = PTR_W'(j);
         end
      end
   end

   // Ready is only offered while idle; a grant in IDLE is a transfer since
   // the arbiter only grants asserted valids.
   assign req_ready_o  = (state_q == ST_IDLE) ? grant : '0;
   assign resp_valid_o = resp_valid_q;
   assign resp_data_o  = result_q;
   assign add_a_o      = a_q;
   assign add_b_o      = b_q;
   assign add_sub_o    = sub_q;
   assign busy_o       = busy_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         rr_ptr_q     <= '0;
         owner_q      <= '0;
         lat_cnt_q    <= '0;
         a_q          <= '0;
         b_q          <= '0;
         sub_q        <= 1'b0;
         result_q     <= '0;
         resp_valid_q <= '0;
         busy_q       <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (|grant) begin
                  a_q       <= req_a_arr[grant_idx];
                  b_q       <= req_b_arr[grant_idx];
                  sub_q     <= req_sub_i[grant_idx];
                  owner_q   <= grant_idx;
                  lat_cnt_q <= '0;
                  busy_q    <= 1'b1;
                  state_q   <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               lat_cnt_q <= lat_cnt_q + CNT_W'(1);
               // Operands have been stable for ADDER_LAT cycles here.
               if (lat_cnt_q == LAST_CNT) begin
                  result_q     <= add_c_i;
                  resp_valid_q <= ONE_HOT0 << owner_q;
                  state_q      <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (resp_ready_i[owner_q]) begin
                  resp_valid_q <= '0;
                  rr_ptr_q     <= (owner_q == LAST_REQ) ? '0 : owner_q + PTR_W'(1);
                  busy_q       <= 1'b0;
                  state_q      <= ST_IDLE;
               end
            end
            default: begin
               resp_valid_q <= '0;
               busy_q       <= 1'b0;
               state_q      <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp16_adder_arbiter.sv
// Bench for fp16_adder_arbiter: three instances (ADDER_LAT 1, 3, 4; two
// requesters each) with a behavioural datapath that only produces its
// result once the operands have been stable long enough.
module tb_fp16_adder_arbiter;

   localparam int NR = 2;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n      [3];
   logic [1:0]  req_valid  [3];
   logic [1:0]  req_ready  [3];
   logic [31:0] req_a      [3];
   logic [31:0] req_b      [3];
   logic [1:0]  req_sub    [3];
   logic [1:0]  resp_valid [3];
   logic [1:0]  resp_ready [3];
   logic [15:0] resp_data  [3];
   logic [15:0] add_a      [3];
   logic [15:0] add_b      [3];
   logic        add_sub    [3];
   logic        busy       [3];

   int total = 0;
   int bad   = 0;

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : (k == 1) ? 3 : 4;
   endfunction

   // Stand-in datapath: exact FP16 results for the known vectors, an
   // arbitrary but deterministic mix otherwise (the block passes bits through).
   function automatic logic [15:0] dp(input logic [15:0] a, input logic [15:0] b, input logic s);
      if (a == 16'h4800 && b == 16'h4500) return s ? 16'h4200 : 16'h4A80;
      if (a == 16'h4000 && b == 16'h3C00 && !s) return 16'h4200;
      return (a ^ {b[7:0], b[15:8]}) + (s ? 16'h1357 : 16'h0246);
   endfunction

   // Round-robin rule: first valid requester at or after p, with wrap.
   function automatic int rr_pick(input logic [1:0] v, input int p);
      for (int j = 0; j < NR; j++) begin
         int idx;
         idx = (p + j) % NR;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   generate
      for (genvar gk = 0; gk < 3; gk++) begin : g_dut
         localparam int LAT = (gk == 0) ? 1 : (gk == 1) ? 3 : 4;
         logic [15:0] add_c;
         logic [15:0] snap_a;
         logic [15:0] snap_b;
         logic        snap_s;
         int          stable = 0;

         always @(negedge clk) begin
            if (add_a[gk] !== snap_a || add_b[gk] !== snap_b || add_sub[gk] !== snap_s) begin
               snap_a <= add_a[gk];
               snap_b <= add_b[gk];
               snap_s <= add_sub[gk];
               stable <= 0;
            end else if (stable < 1000) begin
               stable <= stable + 1;
            end
         end

         always_comb begin
            add_c = 16'hDEAD;
            if (stable >= LAT - 1) add_c = dp(add_a[gk], add_b[gk], add_sub[gk]);
         end

         fp16_adder_arbiter #(
            .NUM_REQ   (NR),
            .ADDER_LAT (LAT)
         ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n[gk]),
            .req_valid_i  (req_valid[gk]),
            .req_ready_o  (req_ready[gk]),
            .req_a_i      (req_a[gk]),
            .req_b_i      (req_b[gk]),
            .req_sub_i    (req_sub[gk]),
            .resp_valid_o (resp_valid[gk]),
            .resp_ready_i (resp_ready[gk]),
            .resp_data_o  (resp_data[gk]),
            .add_a_o      (add_a[gk]),
            .add_b_o      (add_b[gk]),
            .add_sub_o    (add_sub[gk]),
            .add_c_i      (add_c),
            .busy_o       (busy[gk])
         );
      end
   endgenerate

   task automatic do_reset(input int k);
      @(negedge clk);
      rst_n[k]      = 1'b0;
      req_valid[k]  = '0;
      resp_ready[k] = '0;
      repeat (2) @(negedge clk);
      rst_n[k] = 1'b1;
   endtask

   task automatic drain(input int k);
      int n;
      req_valid[k]  = '0;
      resp_ready[k] = 2'b11;
      n = 0;
      while (busy[k] !== 1'b0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (busy[k] !== 1'b0) begin
         bad++;
         $display("FAIL drain_timeout k=%0d got busy=%b exp=0", k, busy[k]);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         total++;
         if (add_a[k] !== 16'h0 || add_b[k] !== 16'h0 || add_sub[k] !== 1'b0) begin
            bad++;
            $display("FAIL reset_operands k=%0d got a=%h b=%h s=%b exp 0", k, add_a[k], add_b[k], add_sub[k]);
         end
         total++;
         if (resp_data[k] !== 16'h0 || resp_valid[k] !== 2'b00) begin
            bad++;
            $display("FAIL reset_resp k=%0d got data=%h valid=%b exp 0", k, resp_data[k], resp_valid[k]);
         end
         total++;
         if (req_ready[k] !== 2'b00 || busy[k] !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl k=%0d got ready=%b busy=%b exp 0", k, req_ready[k], busy[k]);
         end
      end
      for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
   endtask

   task automatic run_single_op(input int k, input int i, input logic [15:0] a,
                                input logic [15:0] b, input logic s, input string nm);
      int          c;
      int          lat;
      logic [1:0]  oh;
      logic [15:0] exp_c;
      lat   = lat_of(k);
      oh    = 2'(1 << i);
      exp_c = dp(a, b, s);
      @(negedge clk);
      req_a[k][16*i +: 16] = a;
      req_b[k][16*i +: 16] = b;
      req_sub[k][i]        = s;
      req_valid[k]         = oh;
      resp_ready[k]        = 2'b11;
      #1;
      total++;
      if (req_ready[k] !== oh) begin
         bad++;
         $display("FAIL %s_ready got=%b exp=%b", nm, req_ready[k], oh);
      end
      c = 0;
      do begin
         @(negedge clk);
         c++;
         req_valid[k] = '0;
         #1;
         if (resp_valid[k] === 2'b00) begin
            total++;
            if (busy[k] !== 1'b1 || add_a[k] !== a || add_b[k] !== b || add_sub[k] !== s) begin
               bad++;
               $display("FAIL %s_exec c=%0d got busy=%b a=%h b=%h s=%b exp 1 %h %h %b",
                        nm, c, busy[k], add_a[k], add_b[k], add_sub[k], a, b, s);
            end
         end
      end while (resp_valid[k] === 2'b00 && c < lat + 20);
      total++;
      if (c != lat + 1) begin
         bad++;
         $display("FAIL %s_latency got=%0d exp=%0d", nm, c, lat + 1);
      end
      total++;
      if (resp_valid[k] !== oh) begin
         bad++;
         $display("FAIL %s_resp_valid got=%b exp=%b", nm, resp_valid[k], oh);
      end
      total++;
      if (resp_data[k] !== exp_c) begin
         bad++;
         $display("FAIL %s_resp_data got=%h exp=%h", nm, resp_data[k], exp_c);
      end
      total++;
      if (add_a[k] !== a || add_b[k] !== b || add_sub[k] !== s) begin
         bad++;
         $display("FAIL %s_resp_operands got a=%h b=%h s=%b exp %h %h %b", nm, add_a[k], add_b[k], add_sub[k], a, b, s);
      end
      @(negedge clk);
      #1;
      total++;
      if (resp_valid[k] !== 2'b00 || busy[k] !== 1'b0) begin
         bad++;
         $display("FAIL %s_release got valid=%b busy=%b exp 00 0", nm, resp_valid[k], busy[k]);
      end
      $display("op %s: k=%0d req%0d a=%h b=%h sub=%b -> %h latency=%0d", nm, k, i, a, b, s, resp_data[k], c);
   endtask

   task automatic test_single_add();
      do_reset(0);
      run_single_op(0, 0, 16'h4800, 16'h4500, 1'b0, "add");
   endtask

   task automatic test_single_sub();
      run_single_op(0, 1, 16'h4800, 16'h4500, 1'b1, "sub");
   endtask

   task automatic test_lat3();
      do_reset(1);
      run_single_op(1, 0, 16'h4000, 16'h3C00, 1'b0, "lat3");
   endtask

   task automatic test_contention();
      int          ptr;
      int          grants;
      int          owner;
      int          cyc;
      int          g;
      int          last_g;
      logic [15:0] exp_data;
      do_reset(0);
      ptr = 0; grants = 0; owner = 0; cyc = 0; exp_data = '0;
      @(negedge clk);
      req_a[0]      = {16'h4000, 16'h4800};
      req_b[0]      = {16'h3C00, 16'h4500};
      req_sub[0]    = 2'b00;
      req_valid[0]  = 2'b11;
      resp_ready[0] = 2'b11;
      while (grants < 4 && cyc < 100) begin
         #1;
         last_g = -1;
         total++;
         if ($countones(req_ready[0]) > 1) begin
            bad++;
            $display("FAIL cont_onehot got=%b exp at most one bit", req_ready[0]);
         end
         if (req_ready[0] !== 2'b00) begin
            g = rr_pick(req_valid[0], ptr);
            total++;
            if (req_ready[0] !== 2'(1 << g)) begin
               bad++;
               $display("FAIL cont_grant got=%b exp=%b", req_ready[0], 2'(1 << g));
            end
            owner    = g;
            exp_data = dp(req_a[0][16*g +: 16], req_b[0][16*g +: 16], req_sub[0][g]);
            ptr      = (g + 1) % NR;
            last_g   = g;
            grants++;
            $display("contention grant %0d -> req%0d", grants, g);
         end
         if (resp_valid[0] !== 2'b00) begin
            total++;
            if (resp_valid[0] !== 2'(1 << owner) || resp_data[0] !== exp_data) begin
               bad++;
               $display("FAIL cont_resp got valid=%b data=%h exp %b %h", resp_valid[0], resp_data[0], 2'(1 << owner), exp_data);
            end
         end
         @(negedge clk);
         cyc++;
         if (last_g >= 0) begin
            req_a[0][16*last_g +: 16] = 16'($urandom);
            req_b[0][16*last_g +: 16] = 16'($urandom);
            req_sub[0][last_g]        = 1'($urandom);
         end
      end
      total++;
      if (grants != 4) begin
         bad++;
         $display("FAIL cont_timeout got=%0d exp=4 grants", grants);
      end
      drain(0);
   endtask

   task automatic test_backpressure();
      int n;
      do_reset(0);
      @(negedge clk);
      req_a[0]      = {16'h4000, 16'h4800};
      req_b[0]      = {16'h3C00, 16'h4500};
      req_sub[0]    = 2'b01;
      req_valid[0]  = 2'b11;
      resp_ready[0] = 2'b00;
      #1;
      total++;
      if (req_ready[0] !== 2'b01) begin
         bad++;
         $display("FAIL bp_first_grant got=%b exp=01", req_ready[0]);
      end
      n = 0;
      do begin
         @(negedge clk);
         req_valid[0]  = 2'b10;
         resp_ready[0] = 2'b10;
         n++;
         #1;
      end while (resp_valid[0] === 2'b00 && n < 20);
      for (int c = 0; c < 10; c++) begin
         total++;
         if (resp_valid[0] !== 2'b01 || resp_data[0] !== 16'h4200 || req_ready[0] !== 2'b00) begin
            bad++;
            $display("FAIL bp_stall c=%0d got valid=%b data=%h ready=%b exp 01 4200 00",
                     c, resp_valid[0], resp_data[0], req_ready[0]);
         end
         @(negedge clk);
         #1;
      end
      resp_ready[0] = 2'b01;
      @(negedge clk);
      #1;
      total++;
      if (busy[0] !== 1'b0 || resp_valid[0] !== 2'b00 || req_ready[0] !== 2'b10) begin
         bad++;
         $display("FAIL bp_release got busy=%b valid=%b ready=%b exp 0 00 10", busy[0], resp_valid[0], req_ready[0]);
      end
      resp_ready[0] = 2'b11;
      n = 0;
      do begin
         @(negedge clk);
         req_valid[0] = 2'b00;
         n++;
         #1;
      end while (resp_valid[0] === 2'b00 && n < 20);
      total++;
      if (resp_valid[0] !== 2'b10 || resp_data[0] !== 16'h4200) begin
         bad++;
         $display("FAIL bp_req1_resp got valid=%b data=%h exp 10 4200", resp_valid[0], resp_data[0]);
      end
      $display("backpressure: stalled 10 cycles, req1 result %h", resp_data[0]);
      drain(0);
   endtask

   task automatic test_reset_mid_exec();
      logic [15:0] a;
      a = 16'($urandom) | 16'h0001;
      do_reset(2);
      @(negedge clk);
      req_a[2][15:0] = a;
      req_b[2][15:0] = 16'($urandom);
      req_sub[2]     = 2'b00;
      req_valid[2]   = 2'b01;
      resp_ready[2]  = 2'b11;
      repeat (3) begin
         @(negedge clk);
         req_valid[2] = 2'b00;
      end
      #2;
      rst_n[2] = 1'b0;
      #1;
      total++;
      if (busy[2] !== 1'b0 || add_a[2] !== 16'h0 || add_b[2] !== 16'h0 || resp_valid[2] !== 2'b00) begin
         bad++;
         $display("FAIL rst_mid_exec got busy=%b a=%h b=%h valid=%b exp 0 0 0 00", busy[2], add_a[2], add_b[2], resp_valid[2]);
      end
      @(negedge clk);
      rst_n[2] = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         #1;
         total++;
         if (resp_valid[2] !== 2'b00 || busy[2] !== 1'b0) begin
            bad++;
            $display("FAIL rst_no_resp c=%0d got valid=%b busy=%b exp 00 0", c, resp_valid[2], busy[2]);
         end
      end
      $display("reset mid-exec: op a=%h discarded", a);
      run_single_op(2, 1, 16'h4800, 16'h4500, 1'b0, "after_rst");
   endtask

   task automatic test_random(input int k, input int ncyc);
      int          ptr;
      int          owner;
      int          gcyc;
      int          lat;
      int          g;
      int          accepted;
      int          ops;
      bit          inflight;
      logic [1:0]  exp_ready;
      logic [1:0]  exp_rv;
      logic [15:0] exp_data;
      lat = lat_of(k);
      do_reset(k);
      ptr = 0; owner = 0; gcyc = 0; inflight = 0; exp_data = '0; ops = 0;
      @(negedge clk);
      req_valid[k]  = 2'b00;
      resp_ready[k] = 2'($urandom);
      for (int cyc = 0; cyc < ncyc; cyc++) begin
         #1;
         accepted  = -1;
         g         = inflight ? -1 : rr_pick(req_valid[k], ptr);
         exp_ready = (g >= 0) ? 2'(1 << g) : 2'b00;
         total++;
         if (req_ready[k] !== exp_ready) begin
            bad++;
            $display("FAIL rand_ready k=%0d cyc=%0d got=%b exp=%b", k, cyc, req_ready[k], exp_ready);
         end
         exp_rv = (inflight && cyc >= gcyc + lat + 1) ? 2'(1 << owner) : 2'b00;
         total++;
         if (resp_valid[k] !== exp_rv) begin
            bad++;
            $display("FAIL rand_resp_valid k=%0d cyc=%0d got=%b exp=%b", k, cyc, resp_valid[k], exp_rv);
         end
         if (exp_rv != 2'b00) begin
            total++;
            if (resp_data[k] !== exp_data) begin
               bad++;
               $display("FAIL rand_resp_data k=%0d cyc=%0d got=%h exp=%h", k, cyc, resp_data[k], exp_data);
            end
         end
         if (g >= 0) begin
            inflight = 1'b1;
            owner    = g;
            gcyc     = cyc;
            exp_data = dp(req_a[k][16*g +: 16], req_b[k][16*g +: 16], req_sub[k][g]);
            accepted = g;
         end else if (exp_rv != 2'b00 && resp_ready[k][owner]) begin
            inflight = 1'b0;
            ptr      = (owner + 1) % NR;
            ops++;
            $display("rand k=%0d cyc=%0d req%0d done data=%h", k, cyc, owner, exp_data);
         end
         @(negedge clk);
         for (int i = 0; i < NR; i++) begin
            if (!(req_valid[k][i] && i != accepted)) begin
               req_valid[k][i]      = 1'($urandom_range(0, 1));
               req_a[k][16*i +: 16] = 16'($urandom);
               req_b[k][16*i +: 16] = 16'($urandom);
               req_sub[k][i]        = 1'($urandom);
            end
         end
         resp_ready[k] = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      end
      total++;
      if (ops < 5) begin
         bad++;
         $display("FAIL rand_progress k=%0d got=%0d exp>=5 ops", k, ops);
      end
      drain(k);
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         rst_n[k]      = 1'b0;
         req_valid[k]  = '0;
         req_a[k]      = '0;
         req_b[k]      = '0;
         req_sub[k]    = '0;
         resp_ready[k] = '0;
      end
      test_reset();
      test_single_add();
      test_single_sub();
      test_contention();
      test_backpressure();
      test_reset_mid_exec();
      test_lat3();
      test_random(0, 300);
      test_random(1, 300);
      test_random(2, 300);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
